// File: rtl/jk_timer_ctrl.sv
// Down-counting interval timer built on a bank of JK stages with start/stop, terminal-count pulse and auto-reload.
// Optional prescaler enabled by defining JK_TIMER_PRESCALE_EN (adds PSC[3:0]).
module jk_timer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETL,
  input  logic             TICK,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA,
  input  logic             START,
  input  logic             STOP,
  input  logic             AUTORL,
`ifdef JK_TIMER_PRESCALE_EN
  input  logic [3:0]       PSC,
`endif
  output logic [WIDTH-1:0] COUNT,
  output logic             RUN,
  output logic             TC
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EXPIRE} state_t;
  typedef enum logic [1:0] {M_HOLD, M_LOAD, M_RELOAD, M_DEC} mode_t;

  state_t           state, state_nxt;
  mode_t            mode;
  logic [WIDTH-1:0] q, rld, j, k, borrow;
  logic             eff_tick;

`ifdef JK_TIMER_PRESCALE_EN
  logic [3:0] psc_cnt;
  logic       psc_clr;

  assign eff_tick = TICK && (psc_cnt == PSC);
  assign psc_clr  = LOAD || (START && state == ST_IDLE) || (state == ST_EXPIRE);

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL)                       psc_cnt <= 4'd0;
    else if (psc_clr)                  psc_cnt <= 4'd0;
    else if (state == ST_RUN && TICK)  psc_cnt <= eff_tick ? 4'd0 : psc_cnt + 4'd1;
  end
`else
  assign eff_tick = TICK;
`endif

  // Request priority: LOAD > STOP > START > count/reload.
  always_comb begin
    state_nxt = state;
    mode      = M_HOLD;
    if (LOAD) begin
      mode = M_LOAD;
      if (STOP)                                state_nxt = ST_IDLE;
      else if (state == ST_EXPIRE)             state_nxt = (DATA != '0) ? ST_RUN : ST_IDLE;
      else if (state == ST_RUN && DATA == '0)  state_nxt = ST_IDLE;
    end else if (STOP && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (START && q != '0) state_nxt = ST_RUN;
        ST_RUN: begin
          if (eff_tick && q != '0) begin
            mode = M_DEC;
            if (q == WIDTH'(1)) state_nxt = ST_EXPIRE;
          end
        end
        ST_EXPIRE: begin
          if (AUTORL) begin
            mode      = M_RELOAD;
            state_nxt = (rld != '0) ? ST_RUN : ST_IDLE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage i toggles on decrement only when every lower stage is zero (ripple borrow).
  always_comb begin
    borrow[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) borrow[i] = borrow[i-1] & ~q[i-1];
    case (mode)
      M_LOAD:   begin j = DATA;   k = ~DATA;  end
      M_RELOAD: begin j = rld;    k = ~rld;   end
      M_DEC:    begin j = borrow; k = borrow; end
      default:  begin j = '0;     k = '0;     end
    endcase
  end

  // JK characteristic equation applied bitwise across the bank.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      q     <= '0;
      rld   <= '0;
      state <= ST_IDLE;
    end else begin
      q     <= (j & ~q) | (~k & q);
      state <= state_nxt;
      if (LOAD) rld <= DATA;
    end
  end

  assign COUNT = q;
  assign RUN   = (state != ST_IDLE);
  assign TC    = (state == ST_EXPIRE);

endmodule

// File: tb/tb_jk_timer_ctrl.sv
// Scoreboard bench for jk_timer_ctrl: driver queues expected outputs, monitor compares after each edge.
module tb_jk_timer_ctrl;

  logic       CLK = 1'b0;
  logic       RESETL = 1'b0;
  logic       TICK = 1'b0, LOAD = 1'b0, START = 1'b0, STOP = 1'b0, AUTORL = 1'b0;
  logic [7:0] DATA = 8'd0;
  logic [7:0] COUNT;
  logic       RUN, TC;
`ifdef JK_TIMER_PRESCALE_EN
  logic [3:0] PSC = 4'd0;
`endif

  typedef struct {
    logic [7:0] cnt;
    logic       run;
    logic       tc;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event async_chk;

  jk_timer_ctrl #(.WIDTH(8)) dut (
    .CLK(CLK), .RESETL(RESETL), .TICK(TICK), .LOAD(LOAD), .DATA(DATA),
    .START(START), .STOP(STOP), .AUTORL(AUTORL),
`ifdef JK_TIMER_PRESCALE_EN
    .PSC(PSC),
`endif
    .COUNT(COUNT), .RUN(RUN), .TC(TC)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, required completion");
    $fatal(1, "timeout");
  end

  // Monitor: one expectation per clock edge (or asynchronous check event).
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK or async_chk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_cmp++;
        if (COUNT !== e.cnt) begin
          n_bad++;
          $display("FAIL %s count: got %0h required %0h", e.nm, COUNT, e.cnt);
        end
        n_cmp++;
        if (RUN !== e.run) begin
          n_bad++;
          $display("FAIL %s run: got %0b required %0b", e.nm, RUN, e.run);
        end
        n_cmp++;
        if (TC !== e.tc) begin
          n_bad++;
          $display("FAIL %s tc: got %0b required %0b", e.nm, TC, e.tc);
        end
      end
    end
  end

  task automatic cyc(input logic l, input logic [7:0] d, input logic s, input logic p,
                     input logic t, input logic a, input logic [7:0] ec,
                     input logic er, input logic et, input string nm);
    exp_t e;
    @(negedge CLK);
    LOAD = l; DATA = d; START = s; STOP = p; TICK = t; AUTORL = a;
    e.cnt = ec; e.run = er; e.tc = et; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic async_reset_check(input string nm);
    exp_t e;
    #2;
    RESETL = 1'b0;
    e.cnt = 8'd0; e.run = 1'b0; e.tc = 1'b0; e.nm = nm;
    sbq.push_back(e);
    -> async_chk;
    @(negedge CLK);
    RESETL = 1'b1;
  endtask

  initial begin
    exp_t e;
    #3;
    e.cnt = 8'd0; e.run = 1'b0; e.tc = 1'b0; e.nm = "reset_init";
    sbq.push_back(e);
    -> async_chk;
    @(negedge CLK);
    RESETL = 1'b1;

    // one-shot count from 3
    cyc(1, 8'd3, 0, 0, 0, 0, 8'd3, 0, 0, "os_load");
    cyc(0, 8'd0, 1, 0, 0, 0, 8'd3, 1, 0, "os_start");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd2, 1, 0, "os_t1");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd1, 1, 0, "os_t2");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd0, 1, 1, "os_tc");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, "os_idle");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, "os_idle2");
    // auto-reload period RLD+1
    cyc(1, 8'd2, 0, 0, 0, 1, 8'd2, 0, 0, "ar_load");
    cyc(0, 8'd0, 1, 0, 0, 1, 8'd2, 1, 0, "ar_start");
    cyc(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 0, "ar_a1");
    cyc(0, 8'd0, 0, 0, 1, 1, 8'd0, 1, 1, "ar_tc1");
    cyc(0, 8'd0, 0, 0, 1, 1, 8'd2, 1, 0, "ar_rl1");
    cyc(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 0, "ar_b1");
    cyc(0, 8'd0, 0, 0, 1, 1, 8'd0, 1, 1, "ar_tc2");
    cyc(0, 8'd0, 0, 0, 1, 1, 8'd2, 1, 0, "ar_rl2");
    // LOAD during EXPIRE overrides reload
    cyc(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 0, "ex_a");
    cyc(0, 8'd0, 0, 0, 1, 1, 8'd0, 1, 1, "ex_tc");
    cyc(1, 8'd7, 0, 0, 1, 1, 8'd7, 1, 0, "ex_load7");
    cyc(0, 8'd0, 0, 0, 1, 1, 8'd6, 1, 0, "ex_dec");
    // STOP freezes count
    cyc(0, 8'd0, 0, 1, 1, 0, 8'd6, 0, 0, "stop");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd6, 0, 0, "stop_hold");
    // START with COUNT==0 ignored
    cyc(1, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, "z_load");
    cyc(0, 8'd0, 1, 0, 1, 0, 8'd0, 0, 0, "z_start");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, "z_hold");
    // LOAD 0 while running
    cyc(1, 8'd5, 0, 0, 0, 0, 8'd5, 0, 0, "l0_load5");
    cyc(0, 8'd0, 1, 0, 0, 0, 8'd5, 1, 0, "l0_start");
    cyc(1, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, "l0_load0");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, "l0_idle");
    // STOP in EXPIRE: TC still seen, then IDLE
    cyc(1, 8'd1, 0, 0, 0, 1, 8'd1, 0, 0, "se_load");
    cyc(0, 8'd0, 1, 0, 0, 1, 8'd1, 1, 0, "se_start");
    cyc(0, 8'd0, 0, 0, 1, 1, 8'd0, 1, 1, "se_tc");
    cyc(0, 8'd0, 0, 1, 1, 1, 8'd0, 0, 0, "se_stop");
    // LOAD with STOP, START while running, no tick holds
    cyc(1, 8'd4, 0, 0, 0, 0, 8'd4, 0, 0, "ls_load");
    cyc(0, 8'd0, 1, 0, 0, 0, 8'd4, 1, 0, "ls_start");
    cyc(1, 8'd9, 0, 1, 1, 0, 8'd9, 0, 0, "ls_both");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd9, 0, 0, "ls_idle");
    cyc(0, 8'd0, 1, 0, 0, 0, 8'd9, 1, 0, "rs_start");
    cyc(0, 8'd0, 1, 0, 0, 0, 8'd9, 1, 0, "rs_start2");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd8, 1, 0, "rs_dec");
    // multi-stage borrow across the whole bank
    cyc(1, 8'h80, 0, 0, 0, 0, 8'h80, 1, 0, "bw_load");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'h7f, 1, 0, "bw_dec");
    @(negedge CLK);
    TICK = 1'b0; LOAD = 1'b0;
    async_reset_check("reset_midrun");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, "post_reset");
`ifdef JK_TIMER_PRESCALE_EN
    PSC = 4'd2;
    cyc(1, 8'd2, 0, 0, 0, 0, 8'd2, 0, 0, "ps_load");
    cyc(0, 8'd0, 1, 0, 0, 0, 8'd2, 1, 0, "ps_start");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd2, 1, 0, "ps_t1");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd2, 1, 0, "ps_t2");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd1, 1, 0, "ps_t3");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd1, 1, 0, "ps_t4");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd1, 1, 0, "ps_t5");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd0, 1, 1, "ps_tc");
    cyc(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, "ps_idle");
`endif
    @(negedge CLK);
    TICK = 1'b0; LOAD = 1'b0; START = 1'b0; STOP = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
